actor_loc_ctrl: RTL and testbench

- Parametrised successor to the single-actor pacman location controller.
- Tracks one actor's (pacman or ghost) current and next tile on a MAP_W x MAP_H grid.
- Moves only on a step tick, holds a buffered turn request, and talks to the collision lookup and the map-RAM writer over explicit req/valid and req/done handshakes.
- One instance per actor sits between the input/AI logic and the shared map RAM arbiter.

---
 rtl/actor_loc_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_actor_loc_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/actor_loc_ctrl.sv
// actor_loc_ctrl: tracks one actor's current and next tile on a MAP_W x MAP_H grid.
// Moves only on step_en. It holds a buffered one-hot turn request. The candidate tile is
// checked through a collision lookup (query_req/coll_valid). The map writer then commits
// the move (wr_req/wr_done).
//
// Build option: define LOC_WRAP_EN to wrap across the map edges (tunnels). Without it,
// an off-map candidate is rejected like a wall and no lookup is issued.
//
// Ports:
//   CLOCK_50, reset          clock, synchronous active-high reset
//   dir_in[3:0]              {up,down,left,right} request, one-hot only
//   step_en                  one-cycle movement tick
//   query_req/x/y            collision lookup strobe and tile
//   coll_valid, coll_type    lookup response
//   wr_req, wr_done          map-write handshake (level request)
//   curr_x/y, next_x/y       committed and target tile
//   heading                  last successful direction
//   busy, bump, move_count   status: not idle, rejected-move pulse, saturating move count
module actor_loc_ctrl #(
  parameter int unsigned X_W       = 6,
  parameter int unsigned Y_W       = 5,
  parameter int unsigned MAP_W     = 40,
  parameter int unsigned MAP_H     = 30,
  parameter int unsigned START_X   = 20,
  parameter int unsigned START_Y   = 20,
  parameter logic [3:0]  WALL_CODE = 4'b0001
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic [3:0]     dir_in,
  input  logic           step_en,
  output logic           query_req,
  output logic [X_W-1:0] query_x,
  output logic [Y_W-1:0] query_y,
  input  logic           coll_valid,
  input  logic [3:0]     coll_type,
  output logic           wr_req,
  input  logic           wr_done,
  output logic [X_W-1:0] curr_x,
  output logic [Y_W-1:0] curr_y,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y,
  output logic [3:0]     heading,
  output logic           busy,
  output logic           bump,
  output logic [15:0]    move_count
);

  localparam logic [X_W-1:0] XMax   = X_W'(MAP_W - 1);
  localparam logic [Y_W-1:0] YMax   = Y_W'(MAP_H - 1);
  localparam logic [X_W-1:0] XStart = X_W'(START_X);
  localparam logic [Y_W-1:0] YStart = Y_W'(START_Y);

  typedef enum logic [1:0] {StIdle, StQuery, StWait, StWrite} state_e;

  typedef struct packed {
    logic           ok;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cand_t;

  // Neighbour tile in direction dir; ok=0 for an off-map tile (no-wrap) or a non-one-hot dir.
  function automatic cand_t step_tile(logic [X_W-1:0] x, logic [Y_W-1:0] y, logic [3:0] dir);
    cand_t c;
    c.ok = 1'b1;
    c.x  = x;
    c.y  = y;
    case (dir)
      4'b1000: begin
        if (y == '0) begin
`ifdef LOC_WRAP_EN
          c.y = YMax;
`else
          c.ok = 1'b0;
`endif
        end else c.y = y - Y_W'(1);
      end
      4'b0100: begin
        if (y == YMax) begin
`ifdef LOC_WRAP_EN
          c.y = '0;
`else
          c.ok = 1'b0;
`endif
        end else c.y = y + Y_W'(1);
      end
      4'b0010: begin
        if (x == '0) begin
`ifdef LOC_WRAP_EN
          c.x = XMax;
`else
          c.ok = 1'b0;
`endif
        end else c.x = x - X_W'(1);
      end
      4'b0001: begin
        if (x == XMax) begin
`ifdef LOC_WRAP_EN
          c.x = '0;
`else
          c.ok = 1'b0;
`endif
        end else c.x = x + X_W'(1);
      end
      default: c.ok = 1'b0;
    endcase
    return c;
  endfunction

  state_e     state;
  logic [3:0] pending;
  logic [3:0] tgt;        // direction of the lookup in flight
  logic       used_pend;  // tgt came from the turn buffer

  logic       dir_onehot;
  logic [3:0] pend_eff;
  logic [3:0] idle_tgt;
  logic       idle_retry_ok;
  logic       wait_retry_ok;
  cand_t      cand_tgt;
  cand_t      cand_head;

  // A one-hot request arriving with step_en already counts as the buffered turn.
  assign dir_onehot    = (dir_in != 4'b0) && ((dir_in & (dir_in - 4'd1)) == 4'b0);
  assign pend_eff      = dir_onehot ? dir_in : pending;
  assign idle_tgt      = (pend_eff != 4'b0) ? pend_eff : heading;
  assign idle_retry_ok = (pend_eff != 4'b0) && (heading != 4'b0) && (heading != pend_eff);
  assign wait_retry_ok = used_pend && (heading != 4'b0) && (heading != tgt);
  assign cand_tgt      = step_tile(curr_x, curr_y, idle_tgt);
  assign cand_head     = step_tile(curr_x, curr_y, heading);
  assign busy          = (state != StIdle);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= StIdle;
      curr_x     <= XStart;
      curr_y     <= YStart;
      next_x     <= XStart;
      next_y     <= YStart;
      heading    <= 4'b0;
      pending    <= 4'b0;
      tgt        <= 4'b0;
      used_pend  <= 1'b0;
      query_req  <= 1'b0;
      query_x    <= XStart;
      query_y    <= YStart;
      wr_req     <= 1'b0;
      bump       <= 1'b0;
      move_count <= 16'h0;
    end else begin
      query_req <= 1'b0;
      bump      <= 1'b0;
      case (state)
        StIdle: begin
          if (step_en && (idle_tgt != 4'b0)) begin
            if (cand_tgt.ok) begin
              query_req <= 1'b1;
              query_x   <= cand_tgt.x;
              query_y   <= cand_tgt.y;
              tgt       <= idle_tgt;
              used_pend <= (pend_eff != 4'b0);
              state     <= StQuery;
            end else if (idle_retry_ok && cand_head.ok) begin
              // Requested turn runs off the map; keep going straight instead.
              query_req <= 1'b1;
              query_x   <= cand_head.x;
              query_y   <= cand_head.y;
              tgt       <= heading;
              used_pend <= 1'b0;
              state     <= StQuery;
            end else begin
              bump <= 1'b1;
            end
          end
        end
        StQuery: state <= StWait;
        StWait: begin
          if (coll_valid) begin
            if (coll_type == WALL_CODE) begin
              if (wait_retry_ok && cand_head.ok) begin
                // Turn blocked: try straight ahead; pending stays for the next tick.
                query_req <= 1'b1;
                query_x   <= cand_head.x;
                query_y   <= cand_head.y;
                tgt       <= heading;
                used_pend <= 1'b0;
                state     <= StQuery;
              end else begin
                bump   <= 1'b1;
                next_x <= curr_x;
                next_y <= curr_y;
                state  <= StIdle;
              end
            end else begin
              next_x  <= query_x;
              next_y  <= query_y;
              heading <= tgt;
              wr_req  <= 1'b1;
              state   <= StWrite;
            end
          end
        end
        StWrite: begin
          if (wr_done) begin
            curr_x <= next_x;
            curr_y <= next_y;
            wr_req <= 1'b0;
            if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
      // Turn buffer: consumed on a successful move, overridden by any new one-hot request.
      if ((state == StWait) && coll_valid && (coll_type != WALL_CODE) && used_pend) begin
        pending <= 4'b0;
      end
      if (dir_onehot) pending <= dir_in;
    end
  end

endmodule

// File: tb/tb_actor_loc_ctrl.sv
module tb_actor_loc_ctrl;

  localparam logic [3:0] Up = 4'b1000, Down = 4'b0100, Left = 4'b0010, Right = 4'b0001;
  localparam logic [3:0] Wall = 4'b0001;
`ifdef LOC_WRAP_EN
  localparam int EdgeX = 0;
  localparam int CountAfterEdge = 35;
`else
  localparam int EdgeX = 39;
  localparam int CountAfterEdge = 34;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  dir_in = 4'b0;
  logic        step_en = 1'b0;
  logic        query_req;
  logic [5:0]  query_x;
  logic [4:0]  query_y;
  logic        coll_valid = 1'b0;
  logic [3:0]  coll_type = 4'b0;
  logic        wr_req;
  logic        wr_done = 1'b0;
  logic [5:0]  curr_x, next_x;
  logic [4:0]  curr_y, next_y;
  logic [3:0]  heading;
  logic        busy, bump;
  logic [15:0] move_count;

  int tests = 0;
  int fails = 0;
  int qpulses = 0;
  int bpulses = 0;

  actor_loc_ctrl dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .dir_in(dir_in), .step_en(step_en),
    .query_req(query_req), .query_x(query_x), .query_y(query_y),
    .coll_valid(coll_valid), .coll_type(coll_type), .wr_req(wr_req), .wr_done(wr_done),
    .curr_x(curr_x), .curr_y(curr_y), .next_x(next_x), .next_y(next_y),
    .heading(heading), .busy(busy), .bump(bump), .move_count(move_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (query_req) qpulses++;
    if (bump) bpulses++;
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic go(input logic [3:0] d);
    dir_in = d;
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    dir_in = 4'b0;
  endtask

  // Wait for a lookup strobe, then respond one cycle later.
  task automatic answer(input logic [3:0] code, output logic ok,
                        output logic [5:0] qx, output logic [4:0] qy);
    ok = 1'b0; qx = '0; qy = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (query_req) begin
        qx = query_x; qy = query_y;
        tick();
        coll_valid = 1'b1; coll_type = code;
        tick();
        coll_valid = 1'b0; coll_type = 4'b0;
        ok = 1'b1;
      end else tick();
    end
  endtask

  task automatic finish_write(input int delay, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (wr_req) begin
        repeat (delay) tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        ok = 1'b1;
      end else tick();
    end
  endtask

  task automatic move(input logic [3:0] d, output logic ok);
    logic a, b;
    logic [5:0] qx;
    logic [4:0] qy;
    go(d);
    answer(4'b0000, a, qx, qy);
    finish_write(0, b);
    ok = a && b;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests++;
    if (curr_x !== 6'd20 || curr_y !== 5'd20) begin
      fails++; $display("FAIL reset_curr: got (%0d,%0d) want (20,20)", curr_x, curr_y);
    end
    tests++;
    if (next_x !== 6'd20 || next_y !== 5'd20) begin
      fails++; $display("FAIL reset_next: got (%0d,%0d) want (20,20)", next_x, next_y);
    end
    tests++;
    if ({query_req, wr_req, bump, busy} !== 4'b0 || heading !== 4'b0 || move_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got q=%b w=%b b=%b busy=%b head=%b cnt=%0d want all 0",
               query_req, wr_req, bump, busy, heading, move_count);
    end
  endtask

  task automatic test_basic_move;
    logic ok;
    logic [5:0] qx;
    logic [4:0] qy;
    go(Up);
    tests++;
    if (query_req !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_query_strobe: got q=%b busy=%b want 1 1", query_req, busy);
    end
    answer(4'b0000, ok, qx, qy);
    tests++;
    if (!ok || qx !== 6'd20 || qy !== 5'd19) begin
      fails++; $display("FAIL basic_query_tile: got ok=%b (%0d,%0d) want (20,19)", ok, qx, qy);
    end
    tests++;
    if (wr_req !== 1'b1 || curr_y !== 5'd20 || next_y !== 5'd19) begin
      fails++;
      $display("FAIL basic_write_phase: got wr=%b cy=%0d ny=%0d want 1 20 19", wr_req, curr_y, next_y);
    end
    finish_write(3, ok);
    tests++;
    if (!ok || curr_x !== 6'd20 || curr_y !== 5'd19 || next_y !== 5'd19) begin
      fails++; $display("FAIL basic_commit: got (%0d,%0d) want (20,19)", curr_x, curr_y);
    end
    tests++;
    if (heading !== Up || move_count !== 16'd1 || busy !== 1'b0 || wr_req !== 1'b0) begin
      fails++;
      $display("FAIL basic_status: got head=%b cnt=%0d busy=%b wr=%b want 1000 1 0 0",
               heading, move_count, busy, wr_req);
    end
  endtask

  task automatic test_turn_retry;
    logic ok, ok2;
    logic [5:0] qx1, qx2;
    logic [4:0] qy1, qy2;
    int b0;
    move(Right, ok);                     // (21,19), heading right
    dir_in = Up; tick(); dir_in = 4'b0;  // buffer a turn without stepping
    b0 = bpulses;
    go(4'b0000);
    answer(Wall, ok, qx1, qy1);
    answer(4'b0000, ok2, qx2, qy2);
    tests++;
    if (!ok || qx1 !== 6'd21 || qy1 !== 5'd18) begin
      fails++; $display("FAIL retry_first_query: got (%0d,%0d) want (21,18)", qx1, qy1);
    end
    tests++;
    if (!ok2 || qx2 !== 6'd22 || qy2 !== 5'd19) begin
      fails++; $display("FAIL retry_second_query: got (%0d,%0d) want (22,19)", qx2, qy2);
    end
    finish_write(0, ok);
    tests++;
    if (!ok || curr_x !== 6'd22 || curr_y !== 5'd19 || heading !== Right || move_count !== 16'd3) begin
      fails++;
      $display("FAIL retry_commit: got (%0d,%0d) head=%b cnt=%0d want (22,19) 0001 3",
               curr_x, curr_y, heading, move_count);
    end
    tests++;
    if (bpulses !== b0) begin
      fails++; $display("FAIL retry_no_bump: got %0d bumps want 0", bpulses - b0);
    end
    // Buffered up-turn must still be pending and taken on the next tick.
    go(4'b0000);
    answer(4'b0000, ok, qx1, qy1);
    finish_write(0, ok2);
    tests++;
    if (!ok || !ok2 || qx1 !== 6'd22 || qy1 !== 5'd18 || heading !== Up || move_count !== 16'd4) begin
      fails++;
      $display("FAIL retry_pending_kept: got (%0d,%0d) head=%b cnt=%0d want (22,18) 1000 4",
               qx1, qy1, heading, move_count);
    end
  endtask

  task automatic test_bump;
    logic ok;
    logic [5:0] qx;
    logic [4:0] qy;
    int b0;
    reset = 1'b1; tick(); reset = 1'b0;
    b0 = bpulses;
    go(Left);
    answer(Wall, ok, qx, qy);
    tests++;
    if (!ok || qx !== 6'd19 || qy !== 5'd20) begin
      fails++; $display("FAIL bump_query: got (%0d,%0d) want (19,20)", qx, qy);
    end
    tests++;
    if (bump !== 1'b1 || busy !== 1'b0 || wr_req !== 1'b0) begin
      fails++; $display("FAIL bump_pulse: got bump=%b busy=%b wr=%b want 1 0 0", bump, busy, wr_req);
    end
    tests++;
    if (curr_x !== 6'd20 || curr_y !== 5'd20 || next_x !== 6'd20 || next_y !== 5'd20 ||
        heading !== 4'b0) begin
      fails++;
      $display("FAIL bump_unchanged: got curr (%0d,%0d) next (%0d,%0d) head=%b want 20,20 0",
               curr_x, curr_y, next_x, next_y, heading);
    end
    tick();
    tests++;
    if (bump !== 1'b0 || bpulses - b0 !== 1) begin
      fails++; $display("FAIL bump_single: got bump=%b pulses=%0d want 0 1", bump, bpulses - b0);
    end
  endtask

  task automatic test_map_edge;
    logic ok, all_ok;
    logic [5:0] qx;
    logic [4:0] qy;
    int q0, b0;
    all_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin move(Up, ok); all_ok &= ok; end
    for (int i = 0; i < 19; i++) begin move(Right, ok); all_ok &= ok; end
    tests++;
    if (!all_ok || curr_x !== 6'd39 || curr_y !== 5'd5 || move_count !== 16'd34) begin
      fails++;
      $display("FAIL edge_reach: got ok=%b (%0d,%0d) cnt=%0d want (39,5) 34",
               all_ok, curr_x, curr_y, move_count);
    end
    q0 = qpulses;
    b0 = bpulses;
    go(Right);
`ifdef LOC_WRAP_EN
    answer(4'b0000, ok, qx, qy);
    tests++;
    if (!ok || qx !== 6'd0 || qy !== 5'd5) begin
      fails++; $display("FAIL edge_wrap_query: got (%0d,%0d) want (0,5)", qx, qy);
    end
    finish_write(0, ok);
    tests++;
    if (!ok || curr_x !== 6'd0 || curr_y !== 5'd5) begin
      fails++; $display("FAIL edge_wrap_commit: got (%0d,%0d) want (0,5)", curr_x, curr_y);
    end
`else
    qx = 6'd0; qy = 5'd0;
    tests++;
    if (bump !== 1'b1 || query_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL edge_reject: got bump=%b q=%b busy=%b want 1 0 0", bump, query_req, busy);
    end
    tick(); tick(); tick();
    tests++;
    if (qpulses !== q0 || bpulses - b0 !== 1 || curr_x !== 6'd39 || curr_y !== 5'd5) begin
      fails++;
      $display("FAIL edge_no_lookup: got q=%0d bumps=%0d (%0d,%0d) want 0 1 (39,5)",
               qpulses - q0, bpulses - b0, curr_x, curr_y);
    end
`endif
  endtask

  task automatic test_dropped_ticks;
    logic ok, ok2;
    logic [5:0] qx;
    logic [4:0] qy;
    int q0;
    q0 = qpulses;
    go(Up);
    tick();                                       // now waiting on the lookup
    step_en = 1'b1; tick(); step_en = 1'b0;       // tick in WAIT
    coll_valid = 1'b1; coll_type = 4'b0; tick(); coll_valid = 1'b0;
    dir_in = 4'b0101; step_en = 1'b1; tick();     // tick and multi-hot dir in WRITE
    dir_in = 4'b0; step_en = 1'b0;
    tests++;
    if (wr_req !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL drop_write_held: got wr=%b busy=%b want 1 1", wr_req, busy);
    end
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (qpulses - q0 !== 1 || curr_y !== 5'd4 || move_count !== 16'(CountAfterEdge + 1)) begin
      fails++;
      $display("FAIL drop_one_move: got lookups=%0d y=%0d cnt=%0d want 1 4 %0d",
               qpulses - q0, curr_y, move_count, CountAfterEdge + 1);
    end
    // Pending must still be empty, so a bare tick follows the heading (up).
    go(4'b0000);
    answer(4'b0000, ok, qx, qy);
    finish_write(0, ok2);
    tests++;
    if (!ok || !ok2 || qx !== 6'(EdgeX) || qy !== 5'd3 || heading !== Up) begin
      fails++;
      $display("FAIL drop_pending_kept: got (%0d,%0d) head=%b want (%0d,3) 1000",
               qx, qy, heading, EdgeX);
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic [5:0] qx;
    logic [4:0] qy;
    go(Left);
    answer(4'b0000, ok, qx, qy);
    tests++;
    if (!ok || wr_req !== 1'b1) begin
      fails++; $display("FAIL midreset_setup: got ok=%b wr=%b want 1 1", ok, wr_req);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    tests++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || curr_x !== 6'd20 || curr_y !== 5'd20 ||
        move_count !== 16'd0 || heading !== 4'b0) begin
      fails++;
      $display("FAIL midreset_abort: got wr=%b busy=%b (%0d,%0d) cnt=%0d head=%b want 0 0 (20,20) 0 0",
               wr_req, busy, curr_x, curr_y, move_count, heading);
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_turn_retry();
    test_bump();
    test_map_edge();
    test_dropped_ticks();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
